// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer block: opcodes, FSM states, PC width.
package pc_seq_pkg;

    localparam int unsigned PcWidth = 4;

    typedef logic [PcWidth-1:0] pc_t;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpJmp  = 4'h1;
    localparam logic [3:0] OpCall = 4'h2;
    localparam logic [3:0] OpRet  = 4'h3;
    localparam logic [3:0] OpLdc  = 4'h4;
    localparam logic [3:0] OpDjnz = 4'h5;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StStopped,
        StErr
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic       fetch_req;
    pc_t        fetch_addr;
    logic       fetch_ack;
    logic [7:0] instr;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  instr
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output instr
    );

endinterface

// File: rtl/pc_seq_stack.sv
// Return-address stack for CALL/RET; push/pop are ignored when full/empty respectively.
module pc_seq_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  pc_t  wdata,
    output pc_t  data,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrW = $clog2(Depth + 1);
    localparam int unsigned IdxW = $clog2(Depth);

    logic [PtrW-1:0] ptr_q;
    pc_t             mem_q [Depth];
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] top_idx;

    assign wr_idx  = IdxW'(ptr_q);
    assign top_idx = IdxW'(ptr_q - 1'b1);
    assign full    = (ptr_q == PtrW'(Depth));
    assign empty   = (ptr_q == '0);
    assign data    = mem_q[top_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (push && !full) begin
            ptr_q <= ptr_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - 1'b1;
        end
    end

    // Entry contents need no reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Tiny program sequencer: fetches 8-bit instructions and walks a 4-bit PC.
// Define PC_SEQ_STACK_EN to build the CALL/RET return stack; otherwise CALL/RET are illegal.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    pc_sequencer_if.master        bus,
    output pc_t                   pc,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_e     state_q, state_d;
    pc_t        pc_q, pc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] instr_q, instr_d;

    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] cnt_dec;
    pc_t        pc_inc;

    assign opcode  = instr_q[7:4];
    assign operand = instr_q[3:0];
    assign cnt_dec = cnt_q - 4'd1;
    assign pc_inc  = pc_q + 1'b1;

`ifdef PC_SEQ_STACK_EN
    logic stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    pc_t  stk_data;

    pc_seq_stack #(
        .Depth (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .clear (stk_clear),
        .push  (stk_push),
        .pop   (stk_pop),
        .wdata (pc_inc),
        .data  (stk_data),
        .full  (stk_full),
        .empty (stk_empty)
    );
`else
    logic unused_stack_depth;
    assign unused_stack_depth = ^STACK_DEPTH;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
`ifdef PC_SEQ_STACK_EN
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
`endif
        unique case (state_q)
            StIdle, StStopped, StErr: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                    cnt_d   = '0;
`ifdef PC_SEQ_STACK_EN
                    stk_clear = 1'b1;
`endif
                end
            end
            StFetch: begin
                // halt wins over a same-cycle ack; the fetched word is dropped
                if (halt) begin
                    state_d = StStopped;
                end else if (bus.fetch_ack) begin
                    instr_d = bus.instr;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (halt) begin
                    state_d = StStopped;
                end else begin
                    state_d = StFetch;
                    case (opcode)
                        OpNop: pc_d = pc_inc;
                        OpJmp: pc_d = operand;
`ifdef PC_SEQ_STACK_EN
                        OpCall: begin
                            if (stk_full) begin
                                state_d = StErr;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = operand;
                            end
                        end
                        OpRet: begin
                            if (stk_empty) begin
                                state_d = StErr;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_data;
                            end
                        end
`endif
                        OpLdc: begin
                            cnt_d = operand;
                            pc_d  = pc_inc;
                        end
                        OpDjnz: begin
                            cnt_d = cnt_dec;
                            pc_d  = (cnt_dec != 4'd0) ? operand : pc_inc;
                        end
                        OpHalt:  state_d = StStopped;
                        default: state_d = StErr;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    assign bus.fetch_req  = (state_q == StFetch);
    assign bus.fetch_addr = pc_q;
    assign pc             = pc_q;
    assign busy           = (state_q == StFetch) || (state_q == StExec);
    assign done           = (state_q == StStopped);
    assign error          = (state_q == StErr);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: program table with a fetch-address scoreboard
// plus hand-written halt, start/halt and reset-mid-fetch sequences.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic reset, start, halt;
    pc_t  pc;
    logic busy, done, error;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .STACK_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .halt  (halt),
        .bus   (bus),
        .pc    (pc),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][7:0] prog;
        logic [3:0]       nfetch;
        logic [7:0][3:0]  addrs;
        logic             exp_done;
        logic             exp_err;
        logic [3:0]       exp_pc;
        logic [3:0]       exp_cnt;
    } vec_t;

    vec_t       vecs[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] mem [16];
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic load(input logic [15:0][7:0] prog);
        for (int i = 0; i < 16; i++) mem[i] = prog[i];
    endtask

    // Called at a negedge; returns at the negedge where the sequencer is in FETCH.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Zero-wait memory: acks every request and checks its address against the scoreboard.
    task automatic run(input int budget);
        int         cyc;
        logic [3:0] e;
        for (cyc = 0; cyc < budget; cyc++) begin
            bus.fetch_ack = 1'b0;
            if (!busy) break;
            if (bus.fetch_req) begin
                bus.fetch_ack = 1'b1;
                bus.instr     = mem[bus.fetch_addr];
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL fetch_extra: addr %0d fetched, none expected", bus.fetch_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("fetch_addr", 32'(bus.fetch_addr), 32'(e));
                end
            end
            @(negedge clk);
        end
        bus.fetch_ack = 1'b0;
        if (cyc >= budget) begin
            n_total++;
            $display("FAIL run_timeout: still busy after %0d cycles, required stop", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        bus.fetch_ack = 1'b0;
        bus.instr     = 8'h00;

        v = '0; v.prog[0] = 8'h00; v.prog[1] = 8'h15; v.prog[5] = 8'hF0;
        v.nfetch = 3; v.addrs[0] = 0; v.addrs[1] = 1; v.addrs[2] = 5;
        v.exp_done = 1; v.exp_pc = 5; vecs.push_back(v);

        v = '0; v.prog[0] = 8'h43; v.prog[1] = 8'h51; v.prog[2] = 8'hF0;
        v.nfetch = 5; v.addrs[0] = 0; v.addrs[1] = 1; v.addrs[2] = 1; v.addrs[3] = 1;
        v.addrs[4] = 2; v.exp_done = 1; v.exp_pc = 2; vecs.push_back(v);

        // DJNZ from cnt=0 wraps to 15; NOP at 15 wraps pc to 0
        v = '0; v.prog[0] = 8'h5E; v.prog[14] = 8'h41; v.prog[15] = 8'h00; v.prog[1] = 8'hF0;
        v.nfetch = 5; v.addrs[0] = 0; v.addrs[1] = 14; v.addrs[2] = 15; v.addrs[3] = 0;
        v.addrs[4] = 1; v.exp_done = 1; v.exp_pc = 1; vecs.push_back(v);

        v = '0; v.prog[0] = 8'h70;
        v.nfetch = 1; v.addrs[0] = 0; v.exp_err = 1; v.exp_pc = 0; vecs.push_back(v);

        v = '0; v.prog[0] = 8'h4A; v.prog[1] = 8'h1C; v.prog[12] = 8'h9F;
        v.nfetch = 3; v.addrs[0] = 0; v.addrs[1] = 1; v.addrs[2] = 12;
        v.exp_err = 1; v.exp_pc = 12; v.exp_cnt = 4'hA; vecs.push_back(v);

`ifdef PC_SEQ_STACK_EN
        v = '0; v.prog[0] = 8'h28; v.prog[8] = 8'h30; v.prog[1] = 8'hF0;
        v.nfetch = 3; v.addrs[0] = 0; v.addrs[1] = 8; v.addrs[2] = 1;
        v.exp_done = 1; v.exp_pc = 1; vecs.push_back(v);

        v = '0; v.prog[0] = 8'h21; v.prog[1] = 8'h22; v.prog[2] = 8'h23; v.prog[3] = 8'h24;
        v.prog[4] = 8'h25; v.nfetch = 5;
        for (int i = 0; i < 5; i++) v.addrs[i] = 4'(i);
        v.exp_err = 1; v.exp_pc = 4; vecs.push_back(v);

        // Follows the full-stack case: start must have emptied the stack
        v = '0; v.prog[0] = 8'h30;
        v.nfetch = 1; v.addrs[0] = 0; v.exp_err = 1; v.exp_pc = 0; vecs.push_back(v);
`else
        v = '0; v.prog[0] = 8'h28;
        v.nfetch = 1; v.addrs[0] = 0; v.exp_err = 1; v.exp_pc = 0; vecs.push_back(v);

        v = '0; v.prog[0] = 8'h30;
        v.nfetch = 1; v.addrs[0] = 0; v.exp_err = 1; v.exp_pc = 0; vecs.push_back(v);
`endif

        #12;
        chk("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        chk("rst_fetch_addr", 32'(bus.fetch_addr), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            v = vecs[k];
            load(v.prog);
            for (int i = 0; i < int'(v.nfetch); i++) exp_q.push_back(v.addrs[i]);
            pulse_start();
            run(200);
            chk($sformatf("v%0d_missing_fetches", k), 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            chk($sformatf("v%0d_done", k), 32'(done), 32'(v.exp_done));
            chk($sformatf("v%0d_error", k), 32'(error), 32'(v.exp_err));
            chk($sformatf("v%0d_pc", k), 32'(pc), 32'(v.exp_pc));
            chk($sformatf("v%0d_cnt", k), 32'(dut.cnt_q), 32'(v.exp_cnt));
        end

        // Halt with ack, halt ignored while stopped, start beats halt, halt in EXEC
        v = '0; v.prog[2] = 8'hF0;
        load(v.prog);
        pulse_start();
        chk("h_fetch0_req", 32'(bus.fetch_req), 32'd1);
        chk("h_fetch0_addr", 32'(bus.fetch_addr), 32'd0);
        bus.fetch_ack = 1'b1; bus.instr = mem[0];
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        chk("h_exec_busy", 32'(busy), 32'd1);
        chk("h_exec_req", 32'(bus.fetch_req), 32'd0);
        @(negedge clk);
        chk("h_fetch1_req", 32'(bus.fetch_req), 32'd1);
        chk("h_fetch1_addr", 32'(bus.fetch_addr), 32'd1);
        bus.fetch_ack = 1'b1; bus.instr = mem[1]; halt = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        chk("h_ack_halt_done", 32'(done), 32'd1);
        chk("h_ack_halt_busy", 32'(busy), 32'd0);
        chk("h_ack_halt_pc", 32'(pc), 32'd1);
        @(negedge clk);
        chk("h_stopped_halt_done", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
        chk("h_start_wins_busy", 32'(busy), 32'd1);
        chk("h_start_wins_addr", 32'(bus.fetch_addr), 32'd0);
        bus.fetch_ack = 1'b1; bus.instr = mem[0];
        @(negedge clk);
        bus.fetch_ack = 1'b0; halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("h_exec_halt_done", 32'(done), 32'd1);
        chk("h_exec_halt_pc", 32'(pc), 32'd0);

        // Reset while a fetch is stalled
        v = '0; v.prog[0] = 8'h16; v.prog[6] = 8'hF0;
        load(v.prog);
        pulse_start();
        bus.fetch_ack = 1'b1; bus.instr = mem[0];
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        @(negedge clk);
        chk("r_fetch6_addr", 32'(bus.fetch_addr), 32'd6);
        repeat (3) @(negedge clk);
        chk("r_stalled_req", 32'(bus.fetch_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("r_async_req", 32'(bus.fetch_req), 32'd0);
        chk("r_async_busy", 32'(busy), 32'd0);
        chk("r_async_pc", 32'(pc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.fetch_ack = 1'b1; bus.instr = mem[6];
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        chk("r_late_ack_busy", 32'(busy), 32'd0);
        chk("r_late_ack_done", 32'(done), 32'd0);
        pulse_start();
        chk("r_restart_req", 32'(bus.fetch_req), 32'd1);
        chk("r_restart_addr", 32'(bus.fetch_addr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
